// File: rtl/des_uart_pkg.sv
// Shared types for the UART front end of the DES datapath.
package des_uart_pkg;

   localparam int BLOCK_W = 64;

   typedef logic [BLOCK_W-1:0] block_t;

   // Explicit encodings keep the state values stable for legacy tooling.
   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      STOP      = 3'd3,
      WAIT_IDLE = 3'd4
   } rx_state_t;

endpackage

// File: rtl/uart_block_rx_if.sv
// Block handshake between the UART packer and the DES core.
interface uart_block_rx_if;
   import des_uart_pkg::*;

   block_t block_data;
   logic   block_valid;
   logic   block_ready;

   modport master (output block_data, output block_valid, input  block_ready);
   modport slave  (input  block_data, input  block_valid, output block_ready);

endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: 2-FF synchroniser, mid-bit sampling FSM, byte strobe.
module uart_rx_byte
   import des_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       serial_in,
   output logic [7:0] rx_byte,
   output logic       byte_strobe,
   output logic       framing_error,
   output logic       busy
);

   localparam int TW = $clog2(CLKS_PER_BIT);
   localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT/2 - 1);
   localparam logic [TW-1:0] T_FULL = TW'(CLKS_PER_BIT - 1);

   logic            sync1;
   logic            rx_s;
   rx_state_t       state;
   logic [TW-1:0]   timer;
   logic [2:0]      bit_idx;
   logic [7:0]      shreg;

   // Bring the asynchronous line into the clock domain; idle level is high.
   always_ff @(posedge clock) begin
      if (reset) begin
         sync1 <= 1'b1;
         rx_s  <= 1'b1;
      end else begin
         sync1 <= serial_in;
         rx_s  <= sync1;
      end
   end

   // Frame FSM: half-bit qualify of start, then full-bit steps to mid-bit samples.
   always_ff @(posedge clock) begin
      if (reset) begin
         state         <= IDLE;
         timer         <= '0;
         bit_idx       <= '0;
         shreg         <= '0;
         rx_byte       <= '0;
         byte_strobe   <= 1'b0;
         framing_error <= 1'b0;
      end else begin
         byte_strobe   <= 1'b0;
         framing_error <= 1'b0;
         case (state)
            IDLE: begin
               timer <= '0;
               if (!rx_s) state <= START;
            end
            START: begin
               if (timer == T_HALF) begin
                  timer   <= '0;
                  bit_idx <= '0;
                  // A start bit that has gone high again by mid-bit is a glitch.
                  state   <= rx_s ? IDLE : DATA;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            DATA: begin
               if (timer == T_FULL) begin
                  timer   <= '0;
                  shreg   <= {rx_s, shreg[7:1]};
                  bit_idx <= bit_idx + 1'b1;
                  if (bit_idx == 3'd7) state <= STOP;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            STOP: begin
               if (timer == T_FULL) begin
                  timer <= '0;
                  if (rx_s) begin
                     rx_byte     <= shreg;
                     byte_strobe <= 1'b1;
                     state       <= IDLE;
                  end else begin
                     framing_error <= 1'b1;
                     state         <= WAIT_IDLE;
                  end
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            WAIT_IDLE: begin
               // A held-low break must not be read as a stream of start bits.
               if (rx_s) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: rtl/uart_block_rx.sv
// UART byte stream to 64-bit DES plaintext blocks, first byte most significant.
module uart_block_rx
   import des_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT    = 868,
   parameter int BYTES_PER_BLOCK = 8
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            serial_in,
   uart_block_rx_if.master blk,
   output logic            framing_error,
   output logic            overrun,
   output logic            busy
);

   localparam int W  = 8 * BYTES_PER_BLOCK;
   localparam int CW = (BYTES_PER_BLOCK > 1) ? $clog2(BYTES_PER_BLOCK) : 1;
   localparam logic [CW-1:0] LAST = CW'(BYTES_PER_BLOCK - 1);

   logic [7:0]    rx_byte;
   logic          byte_strobe;
   logic [W-1:0]  asm_q;
   logic [W-1:0]  asm_next;
   logic [CW-1:0] cnt;
   logic          blk_done;
   logic          accept;
   block_t        data_q;
   logic          valid_q;

   uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
      .clock         (clock),
      .reset         (reset),
      .serial_in     (serial_in),
      .rx_byte       (rx_byte),
      .byte_strobe   (byte_strobe),
      .framing_error (framing_error),
      .busy          (busy)
   );

   // The completing byte is folded in combinationally so the block loads with it.
   assign asm_next = {asm_q[W-9:0], rx_byte};
   assign blk_done = byte_strobe && (cnt == LAST);
   assign accept   = valid_q && blk.block_ready;

   // Byte packer: shift in each good byte and count toward a full block.
   always_ff @(posedge clock) begin
      if (reset) begin
         asm_q <= '0;
         cnt   <= '0;
      end else if (byte_strobe) begin
         asm_q <= asm_next;
         cnt   <= (cnt == LAST) ? '0 : cnt + 1'b1;
      end
   end

   // Output holding register: load when free or being drained, else drop and flag.
   always_ff @(posedge clock) begin
      if (reset) begin
         data_q  <= '0;
         valid_q <= 1'b0;
         overrun <= 1'b0;
      end else begin
         overrun <= 1'b0;
         if (blk_done) begin
            if (!valid_q || blk.block_ready) begin
               data_q  <= block_t'(asm_next);
               valid_q <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end else if (accept) begin
            valid_q <= 1'b0;
         end
      end
   end

   assign blk.block_data  = data_q;
   assign blk.block_valid = valid_q;

endmodule

// File: tb/tb_uart_block_rx.sv
// Randomised bench for uart_block_rx against a byte-list/block-queue reference.
module tb_uart_block_rx;
   import des_uart_pkg::*;

   localparam int CPB = 16;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic serial_in = 1'b1;
   logic framing_error, overrun, busy;

   uart_block_rx_if bus ();

   uart_block_rx #(.CLKS_PER_BIT(CPB), .BYTES_PER_BLOCK(8)) dut (
      .clock         (clock),
      .reset         (reset),
      .serial_in     (serial_in),
      .blk           (bus),
      .framing_error (framing_error),
      .overrun       (overrun),
      .busy          (busy)
   );

   always #5 clock = ~clock;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Monitor: log accepted blocks, error pulse cycles and held-data violations.
   block_t got_q[$];
   int     fe_cyc = 0, ov_cyc = 0, hold_viol = 0;
   logic   prev_hold = 1'b0;
   block_t prev_data = '0;
   always @(negedge clock) begin
      if (reset) begin
         prev_hold <= 1'b0;
      end else begin
         if (bus.block_valid && bus.block_ready) got_q.push_back(bus.block_data);
         if (prev_hold && (!bus.block_valid || bus.block_data !== prev_data))
            hold_viol <= hold_viol + 1;
         prev_hold <= bus.block_valid && !bus.block_ready;
         prev_data <= bus.block_data;
         if (framing_error) fe_cyc <= fe_cyc + 1;
         if (overrun)       ov_cyc <= ov_cyc + 1;
      end
   end

   // Reference model: good bytes accumulate; every 8 form one block, MSB-first.
   logic [7:0] pend[$];
   block_t     made_q[$];
   block_t     exp_q[$];
   int         got_rd = 0, exp_rd = 0, fe_exp = 0, ov_exp = 0;
   logic [7:0] t1b[8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
   logic [7:0] t2b[8] = '{8'h99, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF, 8'h00};
   logic       t6_done = 1'b0;

   function automatic block_t pack(input logic [7:0] q[$]);
      block_t r = '0;
      foreach (q[i]) r = (r << 8) | block_t'(q[i]);
      return r;
   endfunction

   task automatic hold(input logic v, input int n);
      serial_in = v;
      repeat (n) begin @(posedge clock); #1; end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop);
      hold(1'b0, CPB);
      for (int i = 0; i < 8; i++) hold(b[i], CPB);
      hold(stop, CPB);
   endtask

   task automatic good(input logic [7:0] b);
      send_byte(b, 1'b1);
      pend.push_back(b);
      if (pend.size() == 8) begin
         made_q.push_back(pack(pend));
         pend.delete();
      end
   endtask

   task automatic good_rand(input int n);
      for (int i = 0; i < n; i++) good(8'($urandom));
   endtask

   task automatic verify(input string tag);
      chk({tag, "_count"}, 64'(got_q.size() - got_rd), 64'(exp_q.size() - exp_rd));
      if (got_q.size() - got_rd == exp_q.size() - exp_rd)
         for (int i = 0; i < exp_q.size() - exp_rd; i++)
            chk({tag, "_block"}, got_q[got_rd + i], exp_q[exp_rd + i]);
      chk({tag, "_ferr"}, 64'(fe_cyc), 64'(fe_exp));
      chk({tag, "_ovr"}, 64'(ov_cyc), 64'(ov_exp));
      chk({tag, "_stable"}, 64'(hold_viol), 64'd0);
      got_rd = got_q.size();
      exp_rd = exp_q.size();
   endtask

   initial begin
      bus.block_ready = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      chk("rst_valid", 64'(bus.block_valid), 64'd0);
      chk("rst_data", bus.block_data, 64'd0);
      chk("rst_ferr", 64'(framing_error), 64'd0);
      chk("rst_ovr", 64'(overrun), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      reset = 1'b0;
      hold(1'b1, 4);

      // Fixed frame with ready high.
      bus.block_ready = 1'b1;
      foreach (t1b[i]) good(t1b[i]);
      hold(1'b1, CPB);
      exp_q.push_back(made_q.pop_front());
      chk("t1_data", bus.block_data, 64'h1122334455667788);
      chk("t1_valid", 64'(bus.block_valid), 64'd0);
      verify("t1");

      // Two blocks with no ready: first held, second dropped with overrun.
      bus.block_ready = 1'b0;
      foreach (t1b[i]) good(t1b[i]);
      hold(1'b1, 4);
      chk("t2_valid_a", 64'(bus.block_valid), 64'd1);
      foreach (t2b[i]) good(t2b[i]);
      hold(1'b1, 4);
      chk("t2_held", bus.block_data, made_q[0]);
      chk("t2_valid_b", 64'(bus.block_valid), 64'd1);
      exp_q.push_back(made_q.pop_front());
      void'(made_q.pop_front());
      ov_exp++;
      bus.block_ready = 1'b1;
      @(posedge clock); #1;
      bus.block_ready = 1'b0;
      chk("t2_drained", 64'(bus.block_valid), 64'd0);
      hold(1'b1, 2);
      verify("t2");

      // Short low glitch on idle line, then a random frame.
      bus.block_ready = 1'b1;
      hold(1'b0, 4);
      hold(1'b1, 30);
      chk("t3_busy", 64'(busy), 64'd0);
      good_rand(8);
      hold(1'b1, CPB);
      exp_q.push_back(made_q.pop_front());
      verify("t3");

      // Bad stop bit mid-block, held break, then the rest of the block.
      good_rand(3);
      send_byte(8'h5A, 1'b0);
      fe_exp++;
      hold(1'b0, 100);
      chk("t4_wait_busy", 64'(busy), 64'd1);
      hold(1'b1, CPB);
      chk("t4_idle", 64'(busy), 64'd0);
      good_rand(5);
      hold(1'b1, CPB);
      exp_q.push_back(made_q.pop_front());
      verify("t4");

      // Reset during bit 4 of byte 6 with a block pending.
      bus.block_ready = 1'b0;
      good_rand(8);
      hold(1'b1, 4);
      chk("t5_pending", 64'(bus.block_valid), 64'd1);
      void'(made_q.pop_front());
      good_rand(5);
      begin
         logic [7:0] b6;
         b6 = 8'($urandom);
         hold(1'b0, CPB);
         for (int i = 0; i < 4; i++) hold(b6[i], CPB);
         hold(b6[4], CPB / 2);
      end
      chk("t5_busy_pre", 64'(busy), 64'd1);
      reset = 1'b1;
      serial_in = 1'b1;
      @(posedge clock); #1;
      chk("t5_valid", 64'(bus.block_valid), 64'd0);
      chk("t5_data", bus.block_data, 64'd0);
      chk("t5_busy", 64'(busy), 64'd0);
      reset = 1'b0;
      pend.delete();
      made_q.delete();
      hold(1'b1, 4);
      bus.block_ready = 1'b1;
      good_rand(8);
      hold(1'b1, CPB);
      exp_q.push_back(made_q.pop_front());
      verify("t5");

      // Ready toggling every cycle across two blocks.
      fork
         begin
            for (int k = 0; k < 20000 && !t6_done; k++) begin
               bus.block_ready = ~bus.block_ready;
               @(posedge clock); #1;
            end
         end
         begin
            good_rand(16);
            hold(1'b1, CPB);
            t6_done = 1'b1;
         end
      join
      bus.block_ready = 1'b1;
      hold(1'b1, 4);
      exp_q.push_back(made_q.pop_front());
      exp_q.push_back(made_q.pop_front());
      verify("t6");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
